serial_master_port: RTL and testbench



---
 rtl/serial_master_port.sv | 161 ++++++++++++++++
 tb/tb_serial_master_port.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_master_port.sv
// Bus-master side of the serial system bus: serialises one address/data request
// MSB-first onto wr_bus and, for reads, deserialises the slave's reply from rd_bus.
module serial_master_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mode,
  output logic                  wr_bus,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  slave_ready,
  input  logic                  slave_valid,
  input  logic                  rd_bus
);

  localparam int SR_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT_RD,
    RECV,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [SR_W-1:0]       sr_q, sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  mode_q, mode_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [CNT_W-1:0]      cnt_inc;
  logic [SR_W-1:0]       rx_shift;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // The outgoing shift register is empty once DATA finishes, so the reply is
  // shifted into its low end and the bit counter is reused for reply bits.
  assign cnt_inc  = bit_cnt_q + CNT_W'(1);
  assign rx_shift = {sr_q[SR_W-2:0], rd_bus};

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = to_cnt_q;
    mode_d       = mode_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    req_ready    = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    rsp_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          sr_d      = {req_addr, (req_mode ? req_wdata : {DATA_WIDTH{1'b0}})};
          mode_d    = req_mode;
          bit_cnt_d = '0;
          err_d     = 1'b0;
          rdata_d   = '0;
          state_d   = ADDR;
        end
      end

      ADDR, DATA: begin
        master_valid = 1'b1;
        // The very first address bit goes out without waiting on the slave.
        if ((state_q == ADDR && bit_cnt_q == '0) || slave_ready) begin
          sr_d      = {sr_q[SR_W-2:0], 1'b0};
          bit_cnt_d = cnt_inc;
          if (state_q == ADDR && cnt_inc == CNT_W'(ADDR_WIDTH)) begin
            state_d = DATA;
          end else if (state_q == DATA && cnt_inc == CNT_W'(SR_W)) begin
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            state_d   = mode_q ? DONE : WAIT_RD;
          end
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      WAIT_RD, RECV: begin
        master_ready = 1'b1;
        if (slave_valid) begin
          sr_d      = rx_shift;
          bit_cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
            rdata_d = rx_shift[DATA_WIDTH-1:0];
            state_d = DONE;
          end else begin
            state_d = RECV;
          end
        end else if (state_q == RECV) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          // A reply bit arriving on the expiry cycle takes priority above.
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (TIMEOUT != 0 && to_cnt_d == TO_W'(TIMEOUT)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign mode      = mode_q & (state_q != IDLE);
  assign wr_bus    = master_valid & sr_q[SR_W-1];
  assign rsp_err   = err_q & (state_q == DONE);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_serial_master_port.sv
// Bench for serial_master_port: directed table plus random transactions, each
// checked cycle by cycle against a transaction-level reference model.
module tb_serial_master_port;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int TO  = 64;
  localparam int BUS = AW + DW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_mode;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mode, wr_bus, master_valid, master_ready;
  logic          slave_ready, slave_valid, rd_bus;

  int checks = 0;
  int errors = 0;

  serial_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid), .master_ready(master_ready),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .rd_bus(rd_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // abort_k: cycle after accept with slave_ready low (0 = none)
  // wait_c : cycles after DATA before slave_valid rises (-1 = never)
  // drop   : reply bits sent before slave_valid falls (0 = full reply)
  typedef struct {
    bit          mode;
    bit [AW-1:0] addr;
    bit [DW-1:0] wdata;
    int          abort_k;
    int          wait_c;
    int          drop;
    bit [DW-1:0] reply;
    bit          hold;
    int          exp_rsp;
    bit          exp_err;
    bit [DW-1:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(bit m, bit [AW-1:0] a, bit [DW-1:0] wd, int ab, int wt,
                              int dr, bit [DW-1:0] rp, bit h, int rsp, bit er, bit [DW-1:0] rd);
    vec_t v;
    v.mode = m; v.addr = a; v.wdata = wd; v.abort_k = ab; v.wait_c = wt;
    v.drop = dr; v.reply = rp; v.hold = h;
    v.exp_rsp = rsp; v.exp_err = er; v.exp_rdata = rd;
    return v;
  endfunction

  // Reference model: outcome of a transaction from the protocol rules alone.
  function automatic vec_t model(vec_t v);
    int w;
    v.exp_err   = 1'b0;
    v.exp_rdata = '0;
    if (v.abort_k >= 2 && v.abort_k <= BUS) begin
      v.exp_rsp = v.abort_k + 1;
      v.exp_err = 1'b1;
    end else if (v.mode) begin
      v.exp_rsp = BUS + 1;
    end else if (v.wait_c < 0 || v.wait_c >= TO) begin
      v.exp_rsp = BUS + 1 + TO;
      v.exp_err = 1'b1;
    end else begin
      w = BUS + 1 + v.wait_c;
      if (v.drop > 0 && v.drop < DW) begin
        v.exp_rsp = w + v.drop + 1;
        v.exp_err = 1'b1;
      end else begin
        v.exp_rsp   = w + DW;
        v.exp_rdata = v.reply;
      end
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, " mode"}, 32'(mode), 32'd0);
    chk({tag, " wr_bus"}, 32'(wr_bus), 32'd0);
    chk({tag, " master_valid"}, 32'(master_valid), 32'd0);
    chk({tag, " master_ready"}, 32'(master_ready), 32'd0);
  endtask

  // Called at a negedge with the port idle; returns at the negedge after DONE.
  task automatic run_txn(input vec_t v, input int idx);
    logic [BUS-1:0] stream;
    int w, nbits;
    bit exp_mv, in_reply;
    string t;
    stream = {v.addr, (v.mode ? v.wdata : {DW{1'b0}})};
    w      = BUS + 1 + v.wait_c;
    nbits  = (v.drop > 0) ? v.drop : DW;
    t      = $sformatf("txn%0d", idx);
    chk({t, " accept_ready"}, 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_mode    = v.mode;
    req_addr    = v.addr;
    req_wdata   = v.wdata;
    slave_ready = 1'b1;
    slave_valid = 1'b0;
    for (int k = 1; k <= v.exp_rsp; k++) begin
      @(negedge clk);
      req_valid = v.hold;
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
      req_mode  = 1'($urandom);
      t = $sformatf("txn%0d c%0d", idx, k);
      exp_mv = (k <= BUS) && (k < v.exp_rsp);
      chk({t, " master_valid"}, 32'(master_valid), 32'(exp_mv));
      if (exp_mv) chk({t, " wr_bus"}, 32'(wr_bus), 32'(stream[BUS-k]));
      if (k < v.exp_rsp) chk({t, " mode"}, 32'(mode), 32'(v.mode));
      chk({t, " master_ready"}, 32'(master_ready),
          32'(!v.mode && k > BUS && k < v.exp_rsp));
      chk({t, " rsp_valid"}, 32'(rsp_valid), 32'(k == v.exp_rsp));
      chk({t, " req_ready"}, 32'(req_ready), 32'd0);
      if (k == v.exp_rsp) begin
        chk({t, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        if (!v.mode) chk({t, " rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
      end
      slave_ready = (k != v.abort_k);
      in_reply    = !v.mode && v.wait_c >= 0 && k >= w && k < w + nbits;
      slave_valid = in_reply;
      rd_bus      = in_reply ? v.reply[DW-1-(k-w)] : 1'($urandom);
    end
    @(negedge clk);
    slave_valid = 1'b0;
    slave_ready = 1'b1;
    t = $sformatf("txn%0d after", idx);
    chk({t, " req_ready"}, 32'(req_ready), 32'd1);
    chk({t, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    if (!v.mode) chk({t, " rdata_hold"}, 32'(rsp_rdata), 32'(v.exp_rdata));
    $display("txn %0d: %s addr=%h wdata=%h abort=%0d wait=%0d drop=%0d -> rsp@%0d err=%0b rdata=%h",
             idx, v.mode ? "WR" : "RD", v.addr, v.wdata, v.abort_k, v.wait_c, v.drop,
             v.exp_rsp, v.exp_err, v.exp_rdata);
  endtask

  vec_t tbl[13];
  vec_t rv;
  int   r;

  initial begin
    tbl[0]  = mk(1, 16'h1234, 8'hA5, 0,  0, 0, 8'h00, 0, 25, 0, 8'h00);
    tbl[1]  = mk(0, 16'h00FF, 8'h77, 0,  3, 0, 8'h3C, 0, 36, 0, 8'h3C);
    tbl[2]  = mk(1, 16'h4321, 8'h5A, 11, 0, 0, 8'h00, 0, 12, 1, 8'h00);
    tbl[3]  = mk(0, 16'hABCD, 8'h00, 0, -1, 0, 8'h00, 0, 89, 1, 8'h00);
    tbl[4]  = mk(0, 16'h0001, 8'h00, 0,  0, 4, 8'hF0, 0, 30, 1, 8'h00);
    tbl[5]  = mk(0, 16'h8000, 8'h00, 0, 63, 0, 8'h81, 0, 96, 0, 8'h81);
    tbl[6]  = mk(0, 16'h1111, 8'h00, 20, 0, 0, 8'h00, 0, 21, 1, 8'h00);
    tbl[7]  = mk(1, 16'hFFFF, 8'hFF, 2,  0, 0, 8'h00, 0, 3,  1, 8'h00);
    tbl[8]  = mk(1, 16'h0000, 8'h00, 24, 0, 0, 8'h00, 0, 25, 1, 8'h00);
    tbl[9]  = mk(0, 16'h5555, 8'h00, 0,  0, 0, 8'h5A, 0, 33, 0, 8'h5A);
    tbl[10] = mk(0, 16'h2222, 8'h00, 0, 64, 0, 8'hC3, 0, 89, 1, 8'h00);
    tbl[11] = mk(1, 16'h0F0F, 8'h3C, 0,  0, 0, 8'h00, 1, 25, 0, 8'h00);
    tbl[12] = mk(1, 16'hA0A0, 8'hC5, 0,  0, 0, 8'h00, 0, 25, 0, 8'h00);

    rstn = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_addr = '0; req_wdata = '0;
    slave_ready = 1'b1; slave_valid = 1'b0; rd_bus = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_txn(tbl[i], i);

    // Reset pulse in the middle of the data phase.
    req_valid = 1'b1; req_mode = 1'b1; req_addr = 16'hBEEF; req_wdata = 8'h11;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    rstn = 1'b0;
    @(negedge clk);
    chk_idle("midreset");
    rstn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk($sformatf("midreset c%0d rsp_valid", k), 32'(rsp_valid), 32'd0);
      chk($sformatf("midreset c%0d master_valid", k), 32'(master_valid), 32'd0);
    end
    $display("txn midreset: WR addr=beef reset during DATA -> bus released, no response");
    run_txn(model(mk(1, 16'hC0DE, 8'h42, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00)), 100);

    for (int i = 0; i < 40; i++) begin
      rv.mode    = 1'($urandom_range(0, 1));
      rv.addr    = AW'($urandom);
      rv.wdata   = DW'($urandom);
      rv.reply   = DW'($urandom);
      rv.hold    = 1'b0;
      rv.abort_k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, BUS)) : 0;
      r          = int'($urandom_range(0, 9));
      rv.wait_c  = (r == 0) ? -1 : ((r == 1) ? int'($urandom_range(60, 70))
                                              : int'($urandom_range(0, 10)));
      rv.drop    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, DW - 1)) : 0;
      rv = model(rv);
      run_txn(rv, 200 + i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
